vec_decrypt_unit: RTL

- Multi-cycle decryption engine. It inverts the vector datapath's word cipher: per-round key XOR with byte rotate, followed by an additive byte chain seeded with the previous cipher byte (lastData).
- Sits beside the ALU on the vector unit's writeback side. It accepts one 32-bit cipher word with its key and chain byte, and returns the plaintext word through a valid/ready handshake.

---
 rtl/vec_decrypt_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/vec_decrypt_unit.sv
// vec_decrypt_unit: multi-cycle inverse of the vector word cipher (byte chain, then key XOR + byte rotate).
// Optional VDEC_AUTOCHAIN_EN: seed L from an internal chain register instead of last_data.
module vec_decrypt_unit #(
  parameter int ROUNDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] cipher_in,
  input  logic [31:0] key_in,
  input  logic [7:0]  last_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] plain_out,
  output logic [7:0]  chain_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, BYTE = 2'd1, MIX = 2'd2, DONE = 2'd3} state_t;

  state_t      state_r, next_state_s;
  logic [31:0] w_r, w_s, x_r, x_s, key_r, key_s, plain_r, plain_s;
  logic [7:0]  l_r, l_s, chain_cap_r, chain_cap_s, chain_out_r, chain_out_s, l_sel_s;
  logic [1:0]  idx_r, idx_s;
  logic [3:0]  round_r, round_s;
  logic        in_ready_r, out_valid_r, busy_r;
  logic        accept_s;
  logic [31:0] x_full_s, kr_s, xk_s, mix_s;

  function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] n);
    case (n)
      2'd0:    rotl_bytes = w;
      2'd1:    rotl_bytes = {w[23:0], w[31:24]};
      2'd2:    rotl_bytes = {w[15:0], w[31:16]};
      2'd3:    rotl_bytes = {w[7:0],  w[31:8]};
      default: rotl_bytes = w;
    endcase
  endfunction

  assign accept_s = in_valid & in_ready_r & (state_r == IDLE);

`ifdef VDEC_AUTOCHAIN_EN
  logic [7:0] chain_reg_r;
  logic       unused_last_data_s;
  assign unused_last_data_s = ^last_data;

  // Chain register: remembers the top cipher byte of the last accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_reg_r <= 8'h00;
    end else if (accept_s) begin
      chain_reg_r <= cipher_in[31:24];
    end else begin
      chain_reg_r <= chain_reg_r;
    end
  end
  assign l_sel_s = chain_reg_r;
`else
  assign l_sel_s = last_data;
`endif

  // Byte differences are taken from the round's starting word, never the partly rebuilt one.
  assign x_full_s = {w_r[31:24] - w_r[23:16], w_r[23:16] - w_r[15:8],
                     w_r[15:8]  - w_r[7:0],   w_r[7:0]   - l_r};
  assign kr_s  = rotl_bytes(key_r, round_r[1:0]);
  assign xk_s  = x_r ^ kr_s;
  assign mix_s = {xk_s[7:0], xk_s[31:8]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = accept_s ? BYTE : IDLE;
      BYTE:    next_state_s = (idx_r == 2'd3) ? MIX : BYTE;
      MIX:     next_state_s = (round_r == 4'd0) ? DONE : BYTE;
      DONE:    next_state_s = out_ready ? IDLE : DONE;
      default: next_state_s = IDLE;
    endcase
  end

  // Datapath next values for each state.
  always_comb begin
    w_s         = w_r;
    x_s         = x_r;
    key_s       = key_r;
    l_s         = l_r;
    chain_cap_s = chain_cap_r;
    idx_s       = idx_r;
    round_s     = round_r;
    plain_s     = plain_r;
    chain_out_s = chain_out_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          w_s         = cipher_in;
          x_s         = 32'h0000_0000;
          key_s       = key_in;
          l_s         = l_sel_s;
          chain_cap_s = cipher_in[31:24];
          idx_s       = 2'd0;
          round_s     = 4'(ROUNDS - 1);
        end else begin
          idx_s = idx_r;
        end
      end
      BYTE: begin
        x_s[{idx_r, 3'b000} +: 8] = x_full_s[{idx_r, 3'b000} +: 8];
        idx_s = idx_r + 2'd1;
      end
      MIX: begin
        w_s = mix_s;
        if (round_r == 4'd0) begin
          plain_s     = mix_s;
          chain_out_s = chain_cap_r;
        end else begin
          round_s = round_r - 4'd1;
        end
      end
      DONE:    idx_s = idx_r;
      default: idx_s = idx_r;
    endcase
  end

  // Datapath and output registers; in_ready lags entry to IDLE by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_r         <= 32'h0000_0000;
      x_r         <= 32'h0000_0000;
      key_r       <= 32'h0000_0000;
      l_r         <= 8'h00;
      chain_cap_r <= 8'h00;
      idx_r       <= 2'd0;
      round_r     <= 4'd0;
      plain_r     <= 32'h0000_0000;
      chain_out_r <= 8'h00;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      w_r         <= w_s;
      x_r         <= x_s;
      key_r       <= key_s;
      l_r         <= l_s;
      chain_cap_r <= chain_cap_s;
      idx_r       <= idx_s;
      round_r     <= round_s;
      plain_r     <= plain_s;
      chain_out_r <= chain_out_s;
      in_ready_r  <= (state_r == IDLE) && (next_state_s == IDLE);
      out_valid_r <= (next_state_s == DONE);
      busy_r      <= (next_state_s != IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign plain_out = plain_r;
  assign chain_out = chain_out_r;

endmodule
